array_rf_sched: RTL and testbench

//  Refresh scheduler: initiator side of the rf_start/rf_done handshake served by array_rf_ctrl.

---
 rtl/mc_pkg.sv | 16 +
 rtl/rf_intv_timer.sv | 36 +++
 rtl/array_rf_sched.sv | 86 ++++++++
 tb/tb_array_rf_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared memory-controller definitions: refresh FSM encoding and default
// refresh parameters used by the scheduler, fsm_ctrl and mc_apb_cfg.
package mc_pkg;

    localparam int RF_INTV_WIDTH_DEF = 16;
    localparam int RF_PEND_MAX_DEF   = 8;
    localparam int RF_PEND_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_REQ   = 2'd1,
        RF_START = 2'd2,
        RF_BUSY  = 2'd3
    } rf_state_t;

endpackage

// File: rtl/rf_intv_timer.sv
// Refresh interval timer: counts cycles while enabled and emits a one-cycle
// tick when the configured interval has elapsed. A ">=" compare means that
// lowering the interval below the current count ticks on the next cycle
// instead of wrapping through the full counter range.
module rf_intv_timer
    import mc_pkg::*;
#(
    parameter int RF_INTV_WIDTH = RF_INTV_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [RF_INTV_WIDTH-1:0] cfg,
    output logic                     tick
);

    logic [RF_INTV_WIDTH-1:0] cnt;
    logic                     active;
    logic                     at_end;

    assign active = en && (cfg != '0);
    assign at_end = (cnt >= (cfg - RF_INTV_WIDTH'(1)));
    assign tick   = active && at_end;

    // Interval counter: held at zero when idle, restarts on every tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + RF_INTV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/array_rf_sched.sv
// Refresh scheduler: tracks postponed refreshes, requests a slot from
// fsm_ctrl, and on grant runs one rf_start/rf_done handshake with
// array_rf_ctrl. Urgency is raised once the postponement budget is used up.
module array_rf_sched
    import mc_pkg::*;
#(
    parameter int RF_INTV_WIDTH = RF_INTV_WIDTH_DEF,
    parameter int RF_PEND_MAX   = RF_PEND_MAX_DEF,
    parameter int RF_PEND_WIDTH = RF_PEND_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mc_rf_en,
    input  logic [RF_INTV_WIDTH-1:0] mc_trefi_cfg,
    output logic                     rf_req,
    output logic                     rf_urgent,
    input  logic                     rf_grant,
    output logic                     rf_start,
    input  logic                     rf_done,
    output logic [RF_PEND_WIDTH-1:0] rf_pend_cnt,
    output logic                     rf_overflow
);

    localparam logic [RF_PEND_WIDTH-1:0] PEND_MAX = RF_PEND_WIDTH'(RF_PEND_MAX);

    rf_state_t state;
    rf_state_t state_next;
    logic      tick;
    logic      done_acc;

    rf_intv_timer #(
        .RF_INTV_WIDTH (RF_INTV_WIDTH)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mc_rf_en),
        .cfg   (mc_trefi_cfg),
        .tick  (tick)
    );

    // Completion only counts while a refresh is actually in flight
    assign done_acc  = rf_done && (state == RF_BUSY);
    assign rf_urgent = (rf_pend_cnt == PEND_MAX);

    // Next-state logic for the refresh handshake
    always_comb begin
        state_next = state;
        case (state)
            RF_IDLE:  if (rf_pend_cnt != '0) state_next = RF_REQ;
            RF_REQ:   if (rf_grant)          state_next = RF_START;
            RF_START:                        state_next = RF_BUSY;
            RF_BUSY:  if (rf_done)           state_next = RF_IDLE;
            default:                         state_next = RF_IDLE;
        endcase
    end

    // State register with registered request/start outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RF_IDLE;
            rf_req   <= 1'b0;
            rf_start <= 1'b0;
        end else begin
            state    <= state_next;
            rf_req   <= (state_next == RF_REQ);
            rf_start <= (state_next == RF_START);
        end
    end

    // Pending count: tick adds, accepted done removes, both together cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_pend_cnt <= '0;
            rf_overflow <= 1'b0;
        end else if (tick && !done_acc) begin
            if (rf_pend_cnt == PEND_MAX) begin
                rf_overflow <= 1'b1;
            end else begin
                rf_pend_cnt <= rf_pend_cnt + RF_PEND_WIDTH'(1);
            end
        end else if (done_acc && !tick && (rf_pend_cnt != '0)) begin
            rf_pend_cnt <= rf_pend_cnt - RF_PEND_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_array_rf_sched.sv
// Scoreboard bench for array_rf_sched: the stimulus side advances a
// behavioural refresh model each clock and queues the expected outputs;
// a monitor on the falling edge pops and compares them.
module tb_array_rf_sched;

    localparam int W  = 16;
    localparam int PM = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mc_rf_en = 1'b0;
    logic [W-1:0]  mc_trefi_cfg = '0;
    logic          rf_grant = 1'b0;
    logic          rf_done = 1'b0;
    logic          rf_req;
    logic          rf_urgent;
    logic          rf_start;
    logic [PW-1:0] rf_pend_cnt;
    logic          rf_overflow;

    always #5 clk = ~clk;

    array_rf_sched #(
        .RF_INTV_WIDTH (W),
        .RF_PEND_MAX   (PM),
        .RF_PEND_WIDTH (PW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mc_rf_en     (mc_rf_en),
        .mc_trefi_cfg (mc_trefi_cfg),
        .rf_req       (rf_req),
        .rf_urgent    (rf_urgent),
        .rf_grant     (rf_grant),
        .rf_start     (rf_start),
        .rf_done      (rf_done),
        .rf_pend_cnt  (rf_pend_cnt),
        .rf_overflow  (rf_overflow)
    );

    typedef struct {
        int pend;
        int req;
        int start;
        int urg;
        int ovf;
    } exp_t;

    exp_t sq[$];
    int   st_cyc[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Reference model: elapsed cycles since last refresh tick, number of
    // refreshes owed, and where the current slot is in its lifecycle.
    int   m_elapsed = 0;
    int   m_pend = 0;
    bit   m_ovf = 0;
    bit   m_wanting = 0;
    bit   m_starting = 0;
    bit   m_inflight = 0;

    function automatic void chk(string nm, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, expv, cyc, $time);
        end
    endfunction

    function automatic void model_reset();
        m_elapsed  = 0;
        m_pend     = 0;
        m_ovf      = 0;
        m_wanting  = 0;
        m_starting = 0;
        m_inflight = 0;
    endfunction

    function automatic void model_edge(bit rst_now, bit e, int c, bit g, bit d);
        bit tick;
        bit acc;
        int owed_before;
        if (!rst_now) begin
            model_reset();
            return;
        end
        // The interval has elapsed when this edge completes cfg cycles
        tick = e && (c != 0) && (m_elapsed + 1 >= c);
        if (!(e && c != 0) || tick) m_elapsed = 0;
        else m_elapsed = m_elapsed + 1;
        acc = m_inflight && d;
        owed_before = m_pend;
        if (tick && !acc) begin
            if (m_pend == PM) m_ovf = 1;
            else m_pend = m_pend + 1;
        end else if (acc && !tick) begin
            m_pend = m_pend - 1;
        end
        if (m_inflight) begin
            if (d) m_inflight = 0;
        end else if (m_starting) begin
            m_starting = 0;
            m_inflight = 1;
        end else if (m_wanting) begin
            if (g) begin
                m_wanting  = 0;
                m_starting = 1;
                st_cyc.push_back(cyc + 1);
            end
        end else if (owed_before != 0) begin
            m_wanting = 1;
        end
    endfunction

    task automatic step(bit e, int c, bit g, bit d);
        bit r;
        exp_t x;
        mc_rf_en     = e;
        mc_trefi_cfg = W'(c);
        rf_grant     = g;
        rf_done      = d;
        @(posedge clk);
        r = rst_n;
        #1;
        model_edge(r, e, c, g, d);
        cyc++;
        x.pend  = m_pend;
        x.req   = m_wanting;
        x.start = m_starting;
        x.urg   = (m_pend == PM);
        x.ovf   = m_ovf;
        sq.push_back(x);
    endtask

    // Responsive fsm_ctrl/array_rf_ctrl stand-in with fixed grant/done delays
    task automatic run_resp(int n, bit e, int c, int gdel, int ddel);
        int wq = 0;
        int bq = 0;
        bit g;
        bit d;
        repeat (n) begin
            g = m_wanting && (wq >= gdel);
            d = m_inflight && (bq >= ddel);
            step(e, c, g, d);
            wq = m_wanting  ? wq + 1 : 0;
            bq = m_inflight ? bq + 1 : 0;
        end
    endtask

    task automatic do_reset(int hold);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req",   int'(rf_req), 0);
        chk("async_rst_start", int'(rf_start), 0);
        chk("async_rst_pend",  int'(rf_pend_cnt), 0);
        chk("async_rst_ovf",   int'(rf_overflow), 0);
        chk("async_rst_urg",   int'(rf_urgent), 0);
        chk("start_queue_at_reset", st_cyc.size(), 0);
        st_cyc.delete();
        model_reset();
        // Stray grant/done while in reset must have no effect
        repeat (hold) step(1'b1, 3, 1'b1, 1'b1);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                x = sq.pop_front();
                chk("pend_cnt", int'(rf_pend_cnt), x.pend);
                chk("rf_req",   int'(rf_req), x.req);
                chk("rf_start", int'(rf_start), x.start);
                chk("rf_urgent", int'(rf_urgent), x.urg);
                chk("rf_overflow", int'(rf_overflow), x.ovf);
                if (rf_start) begin
                    if (st_cyc.size() == 0) chk("start_unexpected", 1, 0);
                    else chk("start_cycle", cyc, st_cyc.pop_front());
                end
            end
        end
    end

    initial begin
        int c;
        bit e;
        bit g;
        bit d;
        int dprob;
        int waited;

        #1;
        chk("init_rst_req",  int'(rf_req), 0);
        chk("init_rst_pend", int'(rf_pend_cnt), 0);
        chk("init_rst_ovf",  int'(rf_overflow), 0);
        repeat (3) step(1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Basic refresh: interval 20, grant after 2, done after 30
        run_resp(120, 1'b1, 20, 2, 30);

        // Saturation and overflow with the slot never granted
        do_reset(1);
        repeat (100) step(1'b1, 10, 1'b0, 1'b0);
        // Disable ticks and drain the backlog
        run_resp(150, 1'b0, 10, 1, 3);
        // Interval of zero never ticks
        repeat (40) step(1'b1, 0, 1'b0, 1'b0);

        // Interval lowered below the running count
        do_reset(1);
        repeat (50) step(1'b1, 100, 1'b0, 1'b0);
        repeat (30) step(1'b1, 5, 1'b0, 1'b0);
        run_resp(60, 1'b1, 5, 0, 2);

        // Randomised traffic: config changes, stray grant/done, mixed rates
        c = 6;
        e = 1'b1;
        dprob = 6;
        for (int i = 0; i < 1600; i++) begin
            if ((i % 64) == 0) begin
                c     = $urandom_range(0, 12);
                e     = ($urandom_range(0, 4) != 0);
                dprob = ($urandom_range(0, 1) != 0) ? 3 : 25;
            end
            g = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, dprob - 1) == 0);
            step(e, c, g, d);
        end

        // Reset asserted while a refresh is in flight
        waited = 0;
        while (!m_inflight && waited < 300) begin
            step(1'b1, 4, 1'b1, 1'b0);
            waited++;
        end
        chk("reached_busy", int'(m_inflight), 1);
        do_reset(3);
        run_resp(60, 1'b1, 7, 1, 4);

        @(negedge clk);
        #1;
        chk("start_queue_empty", st_cyc.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
